branch_amend_multi: RTL and testbench

Multi-lane successor of the single-lane second-stage branch amend register, sitting between EXE_up and PREMEM. It holds one bundle of `LANES` instructions, ordered oldest-first. It selects the oldest lane that needs repair and issues a one-shot flush with that lane's correction data. It kills wrong-path lanes younger than the branch's delay slot, including a delay slot that arrives in the next bundle, and counts mispredicts.

---
 rtl/branch_amend_multi_if.sv | 50 +++++
 rtl/branch_amend_multi.sv | 130 +++++++++++++
 tb/tb_branch_amend_multi.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_amend_multi_if.sv
// Bundle bus around the multi-lane branch amend stage: upstream bundle, PREMEM side,
// branch flush request and the exception/risk controls.
interface branch_amend_multi_if #(
  parameter int LANES  = 2,
  parameter int DW     = 32,
  parameter int CKPT_W = 8,
  parameter int CNT_W  = 16
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic                    exc_flush_i;
  logic                    mem_risk_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [LANES-1:0]        in_lane_valid_i;
  logic [LANES-1:0]        in_repair_i;
  logic [LANES-1:0]        in_corr_take_i;
  logic [LANES*32-1:0]     in_corr_dest_i;
  logic [LANES*32-1:0]     in_vaddr_i;
  logic [LANES*CKPT_W-1:0] in_ckpt_i;
  logic [LANES*DW-1:0]     in_data_i;
  logic                    out_ready_i;
  logic                    out_valid_o;
  logic [LANES-1:0]        out_lane_valid_o;
  logic [LANES*32-1:0]     out_vaddr_o;
  logic [LANES*DW-1:0]     out_data_o;
  logic                    flush_o;
  logic [31:0]             flush_vaddr_o;
  logic [31:0]             flush_dest_o;
  logic                    flush_take_o;
  logic [CKPT_W-1:0]       flush_ckpt_o;
  logic [LW-1:0]           flush_lane_o;
  logic [CNT_W-1:0]        mispredict_cnt_o;

  modport master (
    output exc_flush_i, mem_risk_i, in_valid_i, in_lane_valid_i, in_repair_i,
           in_corr_take_i, in_corr_dest_i, in_vaddr_i, in_ckpt_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_lane_valid_o, out_vaddr_o, out_data_o, flush_o,
           flush_vaddr_o, flush_dest_o, flush_take_o, flush_ckpt_o, flush_lane_o,
           mispredict_cnt_o
  );

  modport slave (
    input  exc_flush_i, mem_risk_i, in_valid_i, in_lane_valid_i, in_repair_i,
           in_corr_take_i, in_corr_dest_i, in_vaddr_i, in_ckpt_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_lane_valid_o, out_vaddr_o, out_data_o, flush_o,
           flush_vaddr_o, flush_dest_o, flush_take_o, flush_ckpt_o, flush_lane_o,
           mispredict_cnt_o
  );
endinterface

// File: rtl/branch_amend_multi.sv
// Multi-lane branch amend stage between EXE_up and PREMEM: picks the oldest mispredicted
// lane, issues a one-shot flush with its correction data and kills younger wrong-path lanes.
module branch_amend_multi #(
  parameter int LANES  = 2,
  parameter int DW     = 32,
  parameter int CKPT_W = 8,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  branch_amend_multi_if.slave bif
);
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LAST = LANES - 1;

  logic [LANES-1:0]        r_lane_v_p0, r_repair_p0, r_take_p0;
  logic [LANES*32-1:0]     r_dest_p0, r_vaddr_p0;
  logic [LANES*CKPT_W-1:0] r_ckpt_p0;
  logic [LANES*DW-1:0]     r_data_p0;
  logic                    r_vld_p0, r_flushed, r_ds_pend;
  logic [CNT_W-1:0]        r_cnt;

  logic [LANES-1:0] w_rep, w_kill, w_load_lv;
  logic [LW-1:0]    w_k;
  logic             w_any_rep, w_k_last, w_ready, w_in_ready, w_xfer, w_flush, w_drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Oldest repairing lane wins: scan from youngest so the lowest index lands last.
  always_comb begin
    w_rep = r_lane_v_p0 & r_repair_p0;
    w_k   = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (w_rep[i]) w_k = LW'(i);
    end
  end

  assign w_any_rep  = r_vld_p0 && (|w_rep);
  assign w_k_last   = (w_k == LW'(LAST));
  assign w_ready    = !(bif.mem_risk_i && w_any_rep);
  assign w_in_ready = !r_vld_p0 || (w_ready && bif.out_ready_i);
  assign w_xfer     = w_in_ready && bif.out_ready_i;
  assign w_flush    = w_any_rep && !bif.mem_risk_i && !r_flushed;
  assign w_drop     = w_flush && !w_k_last;

  // Lanes beyond the delay slot are wrong-path; an incoming bundle only contributes its
  // lane 0 when that lane is the delay slot of the branch that just flushed or is pending.
  always_comb begin
    w_kill    = '0;
    w_load_lv = bif.in_lane_valid_i;
    for (int i = 0; i < LANES; i++) begin
      w_kill[i] = w_any_rep && (i > int'(w_k) + 1);
    end
    if ((w_flush && w_k_last) || r_ds_pend) begin
      w_load_lv    = '0;
      w_load_lv[0] = bif.in_lane_valid_i[0];
    end
  end

  always_comb begin
    bif.flush_vaddr_o = '0;
    bif.flush_dest_o  = '0;
    bif.flush_take_o  = 1'b0;
    bif.flush_ckpt_o  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_any_rep && (w_k == LW'(i))) begin
        bif.flush_vaddr_o = r_vaddr_p0[i*32 +: 32];
        bif.flush_dest_o  = r_dest_p0[i*32 +: 32];
        bif.flush_take_o  = r_take_p0[i];
        bif.flush_ckpt_o  = r_ckpt_p0[i*CKPT_W +: CKPT_W];
      end
    end
  end

  assign bif.in_ready_o       = w_in_ready;
  assign bif.out_valid_o      = r_vld_p0 && w_ready;
  assign bif.out_lane_valid_o = r_lane_v_p0 & ~w_kill;
  assign bif.out_vaddr_o      = r_vaddr_p0;
  assign bif.out_data_o       = r_data_p0;
  assign bif.flush_o          = w_flush;
  assign bif.flush_lane_o     = w_any_rep ? w_k : '0;
  assign bif.mispredict_cnt_o = r_cnt;

  // p0 stage boundary: EXE_up bundle captured here and presented to PREMEM next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld_p0    <= 1'b0;
      r_flushed   <= 1'b0;
      r_ds_pend   <= 1'b0;
      r_cnt       <= '0;
      r_lane_v_p0 <= '0;
      r_repair_p0 <= '0;
      r_take_p0   <= '0;
      r_dest_p0   <= '0;
      r_vaddr_p0  <= '0;
      r_ckpt_p0   <= '0;
      r_data_p0   <= '0;
    end else begin
      if (w_flush) r_cnt <= sat_inc(r_cnt);
      if (bif.exc_flush_i) begin
        r_vld_p0    <= 1'b0;
        r_flushed   <= 1'b0;
        r_ds_pend   <= 1'b0;
        r_lane_v_p0 <= '0;
      end else if (w_xfer) begin
        r_flushed <= 1'b0;
        if (bif.in_valid_i) begin
          r_vld_p0    <= !w_drop;
          r_lane_v_p0 <= w_drop ? '0 : w_load_lv;
          r_ds_pend   <= 1'b0;
          r_repair_p0 <= bif.in_repair_i;
          r_take_p0   <= bif.in_corr_take_i;
          r_dest_p0   <= bif.in_corr_dest_i;
          r_vaddr_p0  <= bif.in_vaddr_i;
          r_ckpt_p0   <= bif.in_ckpt_i;
          r_data_p0   <= bif.in_data_i;
        end else begin
          r_vld_p0    <= 1'b0;
          r_lane_v_p0 <= '0;
          r_ds_pend   <= r_ds_pend || (w_flush && w_k_last);
        end
      end else if (w_flush) begin
        r_flushed <= 1'b1;
        if (w_k_last) r_ds_pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_branch_amend_multi.sv
// Directed scoreboard bench for branch_amend_multi (LANES=2, CNT_W=2): stimulus queues the
// expected bundles and flushes, a negedge monitor pops and compares them as they appear.
module tb_branch_amend_multi;
  logic clk;
  logic rst;

  branch_amend_multi_if #(.LANES(2), .DW(32), .CKPT_W(8), .CNT_W(2)) bif ();

  branch_amend_multi #(.LANES(2), .DW(32), .CKPT_W(8), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  typedef struct packed {
    logic [1:0]  lv;
    logic [31:0] base;
  } bexp_t;

  typedef struct packed {
    logic        lane;
    logic        take;
    logic [31:0] base;
  } fexp_t;

  bexp_t qb[$];
  fexp_t qf[$];
  bexp_t eb;
  fexp_t ef;
  int    n_vec = 0;
  int    n_err = 0;
  int    nf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ev_vaddr(input logic [31:0] b, input int i);
    return b + 32'(4 * i);
  endfunction
  function automatic logic [31:0] ev_data(input logic [31:0] b, input int i);
    return {b[15:0], 16'hD000 + 16'(i)};
  endfunction
  function automatic logic [31:0] ev_dest(input int i);
    return 32'h8000_1000 + 32'(16 * i);
  endfunction
  function automatic logic [7:0] ev_ckpt(input logic [31:0] b, input int i);
    return b[15:8] + 8'(i);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic v, input logic [1:0] lv, input logic [1:0] rep,
                            input logic [1:0] take, input logic [31:0] b);
    bif.in_valid_i      = v;
    bif.in_lane_valid_i = lv;
    bif.in_repair_i     = rep;
    bif.in_corr_take_i  = take;
    for (int i = 0; i < 2; i++) begin
      bif.in_vaddr_i[i*32 +: 32]    = ev_vaddr(b, i);
      bif.in_data_i[i*32 +: 32]     = ev_data(b, i);
      bif.in_corr_dest_i[i*32 +: 32] = ev_dest(i);
      bif.in_ckpt_i[i*8 +: 8]       = ev_ckpt(b, i);
    end
  endtask

  task automatic idle;
    set_bundle(1'b0, 2'b00, 2'b00, 2'b00, 32'h0);
  endtask

  task automatic push_b(input logic [1:0] lv, input logic [31:0] b);
    qb.push_back('{lv: lv, base: b});
  endtask

  task automatic push_f(input logic lane, input logic take, input logic [31:0] b);
    qf.push_back('{lane: lane, take: take, base: b});
  endtask

  // Monitor: every presented bundle transfer and every flush pulse must match the queue head.
  always @(negedge clk) begin
    if (rst) begin
      if (bif.out_valid_o && bif.out_ready_i) begin
        if (qb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL bundle_extra: got lanes %b, required no bundle", bif.out_lane_valid_o);
        end else begin
          eb = qb.pop_front();
          chk("bundle_lane_valid", 64'(bif.out_lane_valid_o), 64'(eb.lv));
          chk("bundle_vaddr", bif.out_vaddr_o, {ev_vaddr(eb.base, 1), ev_vaddr(eb.base, 0)});
          chk("bundle_data", bif.out_data_o, {ev_data(eb.base, 1), ev_data(eb.base, 0)});
        end
      end
      if (bif.flush_o) begin
        if (qf.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL flush_extra: got flush at %0h, required no flush", bif.flush_vaddr_o);
        end else begin
          ef = qf.pop_front();
          chk("flush_lane", 64'(bif.flush_lane_o), 64'(ef.lane));
          chk("flush_vaddr", 64'(bif.flush_vaddr_o), 64'(ev_vaddr(ef.base, int'(ef.lane))));
          chk("flush_dest", 64'(bif.flush_dest_o), 64'(ev_dest(int'(ef.lane))));
          chk("flush_take", 64'(bif.flush_take_o), 64'(ef.take));
          chk("flush_ckpt", 64'(bif.flush_ckpt_o), 64'(ev_ckpt(ef.base, int'(ef.lane))));
        end
      end
    end
  end

  task automatic chk_reset_state;
    @(negedge clk);
    chk("rst_out_valid", 64'(bif.out_valid_o), 64'd0);
    chk("rst_in_ready", 64'(bif.in_ready_o), 64'd1);
    chk("rst_flush", 64'(bif.flush_o), 64'd0);
    chk("rst_cnt", 64'(bif.mispredict_cnt_o), 64'd0);
    chk("rst_lane_valid", 64'(bif.out_lane_valid_o), 64'd0);
    chk("rst_vaddr", bif.out_vaddr_o, 64'd0);
    chk("rst_data", bif.out_data_o, 64'd0);
    chk("rst_flush_dest", 64'(bif.flush_dest_o), 64'd0);
  endtask

  initial begin
    rst             = 1'b0;
    bif.exc_flush_i = 1'b0;
    bif.mem_risk_i  = 1'b0;
    bif.out_ready_i = 1'b1;
    idle();
    tick();
    tick();
    chk_reset_state();
    tick();
    rst = 1'b1;

    // Plain streaming, including a repair bit on an invalid lane that must be ignored.
    set_bundle(1'b1, 2'b11, 2'b00, 2'b00, 32'h0100); push_b(2'b11, 32'h0100); tick();
    set_bundle(1'b1, 2'b10, 2'b01, 2'b00, 32'h0200); push_b(2'b10, 32'h0200); tick();
    set_bundle(1'b1, 2'b01, 2'b10, 2'b00, 32'h0300); push_b(2'b01, 32'h0300); tick();
    idle(); tick(); tick();

    // Lane 0 mispredict: flush one cycle later, bundle arriving on the flush cycle dropped.
    set_bundle(1'b1, 2'b11, 2'b01, 2'b01, 32'h1000);
    push_b(2'b11, 32'h1000); push_f(1'b0, 1'b1, 32'h1000);
    tick();
    set_bundle(1'b1, 2'b11, 2'b00, 2'b00, 32'h1100);
    @(negedge clk);
    chk("t1_flush", 64'(bif.flush_o), 64'd1);
    chk("t1_lane_valid", 64'(bif.out_lane_valid_o), 64'b11);
    chk("t1_in_ready", 64'(bif.in_ready_o), 64'd1);
    tick();
    idle();
    @(negedge clk);
    chk("t1_dropped", 64'(bif.out_valid_o), 64'd0);
    chk("t1_cnt", 64'(bif.mispredict_cnt_o), 64'd1);
    tick();

    // MEM risk blocks the flush, output and input for three cycles.
    set_bundle(1'b1, 2'b11, 2'b01, 2'b01, 32'h2000);
    push_b(2'b11, 32'h2000); push_f(1'b0, 1'b1, 32'h2000);
    tick();
    idle();
    bif.mem_risk_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t2_risk_flush", 64'(bif.flush_o), 64'd0);
      chk("t2_risk_out_valid", 64'(bif.out_valid_o), 64'd0);
      chk("t2_risk_in_ready", 64'(bif.in_ready_o), 64'd0);
      tick();
    end
    bif.mem_risk_i = 1'b0;
    @(negedge clk);
    chk("t2_flush_after_risk", 64'(bif.flush_o), 64'd1);
    tick();
    @(negedge clk);
    chk("t2_cnt", 64'(bif.mispredict_cnt_o), 64'd2);
    chk("t2_empty", 64'(bif.out_valid_o), 64'd0);
    tick();

    // Last-lane mispredict: delay slot arrives after two empty cycles, only lane 0 kept.
    set_bundle(1'b1, 2'b11, 2'b10, 2'b10, 32'h3000);
    push_b(2'b11, 32'h3000); push_f(1'b1, 1'b1, 32'h3000);
    tick();
    idle();
    @(negedge clk);
    chk("t3_flush_lane", 64'(bif.flush_lane_o), 64'd1);
    chk("t3_lane_valid", 64'(bif.out_lane_valid_o), 64'b11);
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t3_gap_empty", 64'(bif.out_valid_o), 64'd0);
      tick();
    end
    set_bundle(1'b1, 2'b11, 2'b00, 2'b00, 32'h4000); push_b(2'b01, 32'h4000);
    tick();
    idle();
    @(negedge clk);
    chk("t3_ds_lane_valid", 64'(bif.out_lane_valid_o), 64'b01);
    chk("t3_cnt", 64'(bif.mispredict_cnt_o), 64'd3);
    tick();

    // Reset in the middle of a held repair bundle.
    set_bundle(1'b1, 2'b11, 2'b01, 2'b01, 32'h5000);
    tick();
    idle();
    rst = 1'b0;
    tick();
    chk_reset_state();
    tick();
    rst = 1'b1;

    // Downstream stall: flush pulses exactly once for the held bundle.
    set_bundle(1'b1, 2'b11, 2'b01, 2'b01, 32'h6000);
    push_b(2'b11, 32'h6000); push_f(1'b0, 1'b1, 32'h6000);
    tick();
    idle();
    bif.out_ready_i = 1'b0;
    nf = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bif.flush_o) nf++;
      chk("t4_stall_out_valid", 64'(bif.out_valid_o), 64'd1);
      tick();
    end
    chk("t4_flush_pulses", 64'(nf), 64'd1);
    bif.out_ready_i = 1'b1;
    tick();
    @(negedge clk);
    chk("t4_cnt", 64'(bif.mispredict_cnt_o), 64'd1);
    chk("t4_empty", 64'(bif.out_valid_o), 64'd0);
    tick();

    // Exception while a repair bundle is held back by MEM risk.
    set_bundle(1'b1, 2'b11, 2'b01, 2'b01, 32'h7000);
    tick();
    idle();
    bif.mem_risk_i  = 1'b1;
    bif.exc_flush_i = 1'b1;
    @(negedge clk);
    chk("t5_exc_flush_blocked", 64'(bif.flush_o), 64'd0);
    tick();
    bif.mem_risk_i  = 1'b0;
    bif.exc_flush_i = 1'b0;
    @(negedge clk);
    chk("t5_exc_out_valid", 64'(bif.out_valid_o), 64'd0);
    chk("t5_exc_flush", 64'(bif.flush_o), 64'd0);
    chk("t5_exc_lane_valid", 64'(bif.out_lane_valid_o), 64'd0);
    chk("t5_exc_cnt", 64'(bif.mispredict_cnt_o), 64'd1);
    tick();

    // Exception and branch flush together: flush still driven and counted, input not loaded.
    set_bundle(1'b1, 2'b11, 2'b01, 2'b00, 32'h7100);
    push_b(2'b11, 32'h7100); push_f(1'b0, 1'b0, 32'h7100);
    tick();
    set_bundle(1'b1, 2'b11, 2'b00, 2'b00, 32'h7200);
    bif.exc_flush_i = 1'b1;
    tick();
    bif.exc_flush_i = 1'b0;
    idle();
    @(negedge clk);
    chk("t5b_out_valid", 64'(bif.out_valid_o), 64'd0);
    chk("t5b_cnt", 64'(bif.mispredict_cnt_o), 64'd2);
    tick();

    // Counter saturation at 3 after five mispredicts from reset.
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int n = 0; n < 5; n++) begin
      set_bundle(1'b1, 2'b11, 2'b01, {1'b0, n[0]}, 32'h8000 + 32'(n * 256));
      push_b(2'b11, 32'h8000 + 32'(n * 256));
      push_f(1'b0, n[0], 32'h8000 + 32'(n * 256));
      tick();
      idle();
      tick();
      @(negedge clk);
      chk("t6_sat_cnt", 64'(bif.mispredict_cnt_o), (n < 2) ? 64'(n + 1) : 64'd3);
    end
    tick();

    repeat (3) tick();
    chk("bundle_queue_drained", 64'(qb.size()), 64'd0);
    chk("flush_queue_drained", 64'(qf.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
